// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) codec scheduler.
// Optional feature macro used by the top: HAMMING_ERR_CNT_EN (corrected-decode counter).
package hamming_pkg;

  // Request modes
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Output-register state
  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  // Requester-id width; never narrower than one bit
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Codeword bit positions: parity bits at 0,1,3, data bits at 2,4,5,6
  localparam int BP_P0 = 0;
  localparam int BP_P1 = 1;
  localparam int BP_D0 = 2;
  localparam int BP_P2 = 3;
  localparam int BP_D1 = 4;
  localparam int BP_D2 = 5;
  localparam int BP_D3 = 6;

endpackage

// File: rtl/hamming74_codec.sv
// Combinational Hamming(7,4) encode / single-bit-correcting decode.
module hamming74_codec
  import hamming_pkg::*;
(
  input  logic       mode_i,
  input  logic [6:0] data_i,
  output logic [6:0] result_o,
  output logic [2:0] syndrome_o,
  output logic       corrected_o
);

  logic [3:0] d;
  logic [6:0] enc;
  logic [6:0] fix;
  logic [2:0] syn;

  // Build the codeword, the syndrome and the corrected word, then select by mode
  always_comb begin
    d = data_i[3:0];
    enc = '0;
    enc[BP_P0] = d[0] ^ d[1] ^ d[3];
    enc[BP_P1] = d[0] ^ d[2] ^ d[3];
    enc[BP_D0] = d[0];
    enc[BP_P2] = d[1] ^ d[2] ^ d[3];
    enc[BP_D1] = d[1];
    enc[BP_D2] = d[2];
    enc[BP_D3] = d[3];

    syn[0] = data_i[BP_P0] ^ data_i[BP_D0] ^ data_i[BP_D1] ^ data_i[BP_D3];
    syn[1] = data_i[BP_P1] ^ data_i[BP_D0] ^ data_i[BP_D2] ^ data_i[BP_D3];
    syn[2] = data_i[BP_P2] ^ data_i[BP_D1] ^ data_i[BP_D2] ^ data_i[BP_D3];

    // Syndrome k points at bit k-1; zero flips nothing
    for (int k = 0; k < 7; k++) begin
      fix[k] = data_i[k] ^ (syn == 3'(k + 1));
    end

    if (mode_i == MODE_DEC) begin
      result_o    = {3'b000, fix[BP_D3], fix[BP_D2], fix[BP_D1], fix[BP_D0]};
      syndrome_o  = syn;
      corrected_o = |syn;
    end else begin
      result_o    = enc;
      syndrome_o  = 3'b000;
      corrected_o = 1'b0;
    end
  end

endmodule

// File: rtl/hamming_codec_sched.sv
// Round-robin scheduler sharing one Hamming(7,4) codec between NUM_REQ requesters,
// with a one-deep registered result stage. Define HAMMING_ERR_CNT_EN to build the
// saturating corrected-decode counter; otherwise err_count is tied to zero.
module hamming_codec_sched
  import hamming_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_mode,
  input  logic [NUM_REQ-1:0][6:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [6:0]              rsp_data,
  output logic [2:0]              rsp_syndrome,
  output logic                    rsp_corrected,
  output logic [15:0]             err_count,
  input  logic                    err_clr
);

  state_e          st_q;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [ID_W-1:0] win;
  logic            found;
  logic            can_acc;
  logic            acc;
  int              idx;

  logic       sel_mode;
  logic [6:0] sel_data;
  logic [6:0] cod_res;
  logic [2:0] cod_syn;
  logic       cod_cor;

  logic [ID_W-1:0] id_q;
  logic [6:0]      data_q;
  logic [2:0]      syn_q;
  logic            cor_q;

  // Pick the first valid requester at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // Accept only when the result register is free or being drained this cycle
  always_comb begin
    can_acc   = !rst && ((st_q == ST_EMPTY) || rsp_ready);
    acc       = can_acc && found;
    req_ready = '0;
    if (acc) req_ready[win] = 1'b1;
    rr_d      = (win == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(win + 1'b1);
    sel_mode  = req_mode[win];
    sel_data  = req_data[win];
  end

  hamming74_codec u_codec (
    .mode_i      (sel_mode),
    .data_i      (sel_data),
    .result_o    (cod_res),
    .syndrome_o  (cod_syn),
    .corrected_o (cod_cor)
  );

  // Result-stage FSM: load on accept, drain on rsp_ready, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_EMPTY;
      rr_q   <= '0;
      id_q   <= '0;
      data_q <= '0;
      syn_q  <= '0;
      cor_q  <= 1'b0;
    end else begin
      case (st_q)
        ST_EMPTY: begin
          if (acc) st_q <= ST_FULL;
        end
        ST_FULL: begin
          if (rsp_ready && !acc) st_q <= ST_EMPTY;
        end
        default: st_q <= ST_EMPTY;
      endcase
      if (acc) begin
        rr_q   <= rr_d;
        id_q   <= win;
        data_q <= cod_res;
        syn_q  <= cod_syn;
        cor_q  <= cod_cor;
      end
    end
  end

  assign rsp_valid     = (st_q == ST_FULL);
  assign rsp_id        = id_q;
  assign rsp_data      = data_q;
  assign rsp_syndrome  = syn_q;
  assign rsp_corrected = cor_q;

`ifdef HAMMING_ERR_CNT_EN
  logic [15:0] err_q;

  // Saturating count of accepted decodes that needed a correction; clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (err_clr) begin
      err_q <= '0;
    end else if (acc && cod_cor && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_hamming_codec_sched.sv
// Scoreboard bench for hamming_codec_sched: a driver issues requests and predicts
// grants and results; a negedge monitor pops and compares every delivered result.
module tb_hamming_codec_sched;
  import hamming_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid, req_mode, req_ready;
  logic [N-1:0][6:0]   req_data;
  logic                rsp_valid, rsp_ready;
  logic [IW-1:0]       rsp_id;
  logic [6:0]          rsp_data;
  logic [2:0]          rsp_syndrome;
  logic                rsp_corrected;
  logic [15:0]         err_count;
  logic                err_clr;

  hamming_codec_sched #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_mode(req_mode),
    .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_syndrome(rsp_syndrome), .rsp_corrected(rsp_corrected),
    .err_count(err_count), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [6:0] data;
    bit         has_exp;
    logic [6:0] ed;
    logic [2:0] es;
    logic       ec;
  } stim_t;

  typedef struct packed {
    logic [1:0] id;
    logic [6:0] d;
    logic [2:0] s;
    logic       c;
  } rsp_t;

  stim_t sq[N][$];
  rsp_t  sb[$];
  int    glog[$];
  int    n_chk = 0, n_fail = 0;
  int    rr_m = 0;
  bit    full_m = 0;
  int    err_m = 0, err_nxt = 0;
  bit    rdy_rand = 0, rdy_fix = 1, clr_rand = 0, clr_fix = 0;
  bit    hold_v = 0;
  rsp_t  held;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference encoder straight from the codeword bit map
  function automatic logic [6:0] ref_enc(input logic [3:0] d);
    logic [6:0] b;
    b[0] = d[0] ^ d[1] ^ d[3];
    b[1] = d[0] ^ d[2] ^ d[3];
    b[2] = d[0];
    b[3] = d[1] ^ d[2] ^ d[3];
    b[4] = d[1];
    b[5] = d[2];
    b[6] = d[3];
    return b;
  endfunction

  // Reference op: decode syndrome as the XOR of the 1-based positions of set bits
  function automatic rsp_t ref_op(input logic mode, input logic [6:0] x, input int id);
    rsp_t r;
    int syn;
    logic [6:0] f;
    r.id = 2'(id);
    if (mode == MODE_ENC) begin
      r.d = ref_enc(x[3:0]); r.s = 3'd0; r.c = 1'b0;
    end else begin
      syn = 0;
      for (int k = 0; k < 7; k++) if (x[k]) syn = syn ^ (k + 1);
      f = x;
      if (syn != 0) f[syn-1] = ~f[syn-1];
      r.d = {3'b000, f[6], f[5], f[4], f[2]};
      r.s = 3'(syn);
      r.c = (syn != 0);
    end
    return r;
  endfunction

  function automatic stim_t mk(input logic m, input logic [6:0] x, input bit h,
                               input logic [6:0] ed, input logic [2:0] es, input logic ec);
    stim_t s;
    s.mode = m; s.data = x; s.has_exp = h; s.ed = ed; s.es = es; s.ec = ec;
    return s;
  endfunction

  function automatic stim_t mk_rand();
    return mk(1'($urandom), 7'($urandom), 0, '0, '0, 1'b0);
  endfunction

  function automatic stim_t mk_corr();
    logic [6:0] cw;
    cw = ref_enc(4'($urandom)) ^ (7'd1 << $urandom_range(0, 6));
    return mk(MODE_DEC, cw, 0, '0, '0, 1'b0);
  endfunction

  function automatic int pending();
    int t = 0;
    for (int r = 0; r < N; r++) t += sq[r].size();
    return t;
  endfunction

  // One clock: drive heads of the request queues, then predict grant and result
  task automatic step();
    int w;
    bit can, found;
    logic [N-1:0] exp_rdy;
    stim_t s;
    rsp_t e;
    @(posedge clk); #1;
    rst   = 1'b0;
    err_m = err_nxt;
    for (int r = 0; r < N; r++) begin
      if (sq[r].size() > 0) begin
        req_valid[r] = 1'b1; req_mode[r] = sq[r][0].mode; req_data[r] = sq[r][0].data;
      end else begin
        req_valid[r] = 1'b0; req_mode[r] = 1'($urandom); req_data[r] = 7'($urandom);
      end
    end
    rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    err_clr   = clr_rand ? ($urandom_range(0, 15) == 0) : clr_fix;
    #1;
    can = !full_m || rsp_ready;
    found = 0; w = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && sq[(rr_m + i) % N].size() > 0) begin found = 1; w = (rr_m + i) % N; end
    end
    exp_rdy = '0;
    if (can && found) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    err_nxt = err_m;
    if (can && found) begin
      s = sq[w].pop_front();
      e = ref_op(s.mode, s.data, w);
`ifdef HAMMING_ERR_CNT_EN
      if (e.c && err_nxt != 65535) err_nxt++;
`endif
      if (s.has_exp) begin e.d = s.ed; e.s = s.es; e.c = s.ec; end
      sb.push_back(e);
      glog.push_back(w);
      rr_m = (w + 1) % N;
      full_m = 1;
    end else if (rsp_ready) begin
      full_m = 0;
    end
`ifdef HAMMING_ERR_CNT_EN
    if (err_clr) err_nxt = 0;
`endif
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock
  task automatic reset_pulse();
    @(posedge clk); #1;
    err_m = err_nxt;
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_fields", {rsp_id, rsp_data, rsp_syndrome, rsp_corrected}, 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_err_count", 32'(err_count), 0);
    sb.delete();
    rr_m = 0; full_m = 0; err_m = 0; err_nxt = 0;
  endtask

  task automatic drain();
    rdy_rand = 0; rdy_fix = 1; clr_rand = 0;
    for (int k = 0; k < 200 && pending() > 0; k++) step();
    chk("drain_pending", 32'(pending()), 0);
    repeat (2) step();
  endtask

  // Monitor: result comparison on handshake, stability while stalled, counter value
  always @(negedge clk) begin
    rsp_t cur, e;
    cur = {rsp_id, rsp_data, rsp_syndrome, rsp_corrected};
`ifdef HAMMING_ERR_CNT_EN
    chk("err_count", 32'(err_count), 32'(err_m));
`else
    chk("err_count_tied", 32'(err_count), 0);
`endif
    if (rsp_valid === 1'b1) begin
      if (hold_v) chk("rsp_stable", 32'(cur), 32'(held));
      if (rsp_ready) begin
        hold_v = 0;
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rsp", 32'(cur), 32'(e));
        end
      end else begin
        hold_v = 1; held = cur;
      end
    end else begin
      hold_v = 0;
    end
  end

  initial begin
    rst = 1'b1; req_valid = '1; req_mode = '0; req_data = '0;
    rsp_ready = 1'b0; err_clr = 1'b0;
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_fields", {rsp_id, rsp_data, rsp_syndrome, rsp_corrected}, 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_err_count", 32'(err_count), 0);
    req_valid = '0;
    repeat (2) @(posedge clk);

    // All requesters valid: grants rotate 0..3, one per cycle
    for (int r = 0; r < N; r++) repeat (2) sq[r].push_back(mk_rand());
    glog.delete();
    repeat (8) step();
    chk("rotation_count", 32'(glog.size()), 8);
    for (int i = 0; i < glog.size() && i < 8; i++) chk("rotation_id", 32'(glog[i]), 32'(i % N));
    chk("rotation_throughput", 32'(pending()), 0);
    drain();

    // Known-answer encode/decode
    sq[0].push_back(mk(MODE_ENC, 7'h0B, 1, 7'h55, 3'd0, 1'b0));
    sq[0].push_back(mk(MODE_DEC, 7'h55, 1, 7'h0B, 3'd0, 1'b0));
    sq[0].push_back(mk(MODE_DEC, 7'h51, 1, 7'h0B, 3'd3, 1'b1));
    drain();

    // Stall with a held result, then release: grant goes to requester at rr
    rdy_fix = 0;
    sq[2].push_back(mk_rand());
    step();
    sq[0].push_back(mk_rand()); sq[1].push_back(mk_rand()); sq[3].push_back(mk_rand());
    repeat (5) step();
    rdy_fix = 1; glog.delete();
    step();
    chk("grant_after_stall", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF, 3);
    drain();

    // Randomized traffic with random backpressure and clears
    rdy_rand = 1; clr_rand = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < N; r++)
        if (sq[r].size() < 3 && $urandom_range(0, 2) == 0) sq[r].push_back(mk_rand());
      step();
    end
    drain();

    // Reset while FULL: held result discarded, rr back to 0
    sq[1].push_back(mk_rand());
    step();
    rdy_fix = 0;
    step();
    sq[0].push_back(mk_rand()); sq[3].push_back(mk_rand());
    reset_pulse();
    rdy_fix = 1; glog.delete();
    step();
    chk("post_reset_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF, 0);
    drain();

`ifdef HAMMING_ERR_CNT_EN
    reset_pulse();
    for (int i = 0; i < 3; i++) sq[i].push_back(mk_corr());
    drain();
    @(negedge clk);
    chk("err_count_3", 32'(err_count), 3);
    sq[0].push_back(mk_corr());
    clr_fix = 1;
    step();
    clr_fix = 0;
    drain();
    @(negedge clk);
    chk("err_clr_wins", 32'(err_count), 0);
    for (int i = 0; i < 65540; i++) sq[i % N].push_back(mk_corr());
    for (int k = 0; k < 70000 && pending() > 0; k++) step();
    drain();
    @(negedge clk);
    chk("err_saturate", 32'(err_count), 32'hFFFF);
`endif

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
